fifo_ctrl: RTL and testbench

FIFO_CTRL -- requirements
Module: fifo_ctrl

---
 rtl/fifo_ctrl_pkg.sv | 16 +
 rtl/fifo_ctrl_if.sv | 28 ++
 rtl/fifo_ptr.sv | 24 ++
 rtl/fifo_ctrl.sv | 88 ++++++++
 tb/tb_fifo_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_ctrl_pkg.sv
// rtl/fifo_ctrl_pkg.sv - shared defaults and types for the FIFO controller
package fifo_ctrl_pkg;

    localparam int DEF_AW       = 2;
    localparam int DEF_DEPTH    = 4;
    localparam int DEF_AE_LEVEL = 1;

    // Accepted operation in one cycle, encoded as {push_ok, pop_ok}
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/fifo_ctrl_if.sv
// rtl/fifo_ctrl_if.sv - producer/consumer and RAM-address bundle of the FIFO controller
interface fifo_ctrl_if #(
    parameter int AW = fifo_ctrl_pkg::DEF_AW
);
    logic          push;
    logic          pop;
    logic          clr;
    logic [AW-1:0] wadr;
    logic [AW-1:0] radr;
    logic          wr;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          ovf;
    logic          udf;

    modport master (
        output push, pop, clr,
        input  wadr, radr, wr, full, empty, almost_full, almost_empty, count, ovf, udf
    );

    modport slave (
        input  push, pop, clr,
        output wadr, radr, wr, full, empty, almost_full, almost_empty, count, ovf, udf
    );
endinterface

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - modulo-DEPTH wrapping pointer with increment enable and sync clear
module fifo_ptr #(
    parameter int AW    = 2,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [AW-1:0] ptr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            // explicit wrap so non-power-of-two depths never reach DEPTH
            ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - FIFO pointer/occupancy controller driving an external dual-port RAM
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = DEF_AE_LEVEL
) (
    input  logic        clk,
    input  logic        rst_n,
    fifo_ctrl_if.slave  bus
);

    logic [AW:0] count_q;
    logic [AW:0] count_d;
    logic        ovf_q;
    logic        udf_q;
    logic        full;
    logic        empty;
    logic        push_ok;
    logic        pop_ok;
    logic        ovf_set;
    logic        udf_set;
    fifo_op_e    op;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);

    assign push_ok = bus.push && (!full || bus.pop) && !bus.clr;
    assign pop_ok  = bus.pop && !empty && !bus.clr;
    // a pop against an empty FIFO is not an error when a push arrives with it
    assign ovf_set = bus.push && full && !bus.pop && !bus.clr;
    assign udf_set = bus.pop && empty && !bus.push && !bus.clr;

    assign op = fifo_op_e'({push_ok, pop_ok});

    always_comb begin
        count_d = count_q;
        unique case (op)
            OP_PUSH: count_d = count_q + 1'b1;
            OP_POP:  count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else if (bus.clr) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            if (ovf_set) ovf_q <= 1'b1;
            if (udf_set) udf_q <= 1'b1;
        end
    end

    fifo_ptr #(.AW(AW), .DEPTH(DEPTH)) u_wptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.clr),
        .inc   (push_ok),
        .ptr   (bus.wadr)
    );

    fifo_ptr #(.AW(AW), .DEPTH(DEPTH)) u_rptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.clr),
        .inc   (pop_ok),
        .ptr   (bus.radr)
    );

    assign bus.wr           = push_ok;
    assign bus.count        = count_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= (AW+1)'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= (AW+1)'(AE_LEVEL));
    assign bus.ovf          = ovf_q;
    assign bus.udf          = udf_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - randomized and directed bench for fifo_ctrl with a 4x8 RAM model
module tb_fifo_ctrl;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = '0;
    logic [7:0] ram [0:D-1];

    int checks = 0;
    int fails  = 0;

    fifo_ctrl_if #(.AW(2)) b ();
    fifo_ctrl_if #(.AW(2)) b3 ();

    fifo_ctrl #(.AW(2), .DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
    fifo_ctrl #(.AW(2), .DEPTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    always #5 clk = ~clk;

    always @(posedge clk) if (b.wr) ram[b.wadr] <= din;

    // reference model: queue of stored bytes, pointer = accepted ops modulo depth
    logic [7:0] q [$];
    int  wcnt = 0;
    int  rcnt = 0;
    bit  m_ovf = 0;
    bit  m_udf = 0;
    bit  exp_wr, exp_pop, obs_wr;
    logic [7:0] exp_dout, obs_dout;

    function automatic logic [12:0] st();
        return {b.count, b.full, b.empty, b.almost_full, b.almost_empty,
                b.ovf, b.udf, b.wadr, b.radr};
    endfunction

    function automatic logic [12:0] mst();
        int n = q.size();
        return {3'(n), n == D, n == 0, n >= D - 1, n <= 1,
                m_ovf, m_udf, 2'(wcnt), 2'(rcnt)};
    endfunction

    function automatic void model_reset();
        q.delete();
        wcnt = 0; rcnt = 0; m_ovf = 0; m_udf = 0;
    endfunction

    // drives one cycle starting just after a rising edge; samples wr/dout at the falling edge
    task automatic cycle(input bit p, input bit po, input bit c, input logic [7:0] d);
        bit full_m, empty_m, pa, qa;
        full_m  = (q.size() == D);
        empty_m = (q.size() == 0);
        pa = p && (!full_m || po) && !c;
        qa = po && !empty_m && !c;
        exp_wr  = pa;
        exp_pop = qa;
        exp_dout = qa ? q[0] : 8'h00;
        b.push = p; b.pop = po; b.clr = c; din = d;
        #4;
        obs_wr   = b.wr;
        obs_dout = ram[b.radr];
        @(posedge clk);
        #1;
        b.push = 0; b.pop = 0; b.clr = 0;
        if (c) begin
            model_reset();
        end else begin
            if (qa) begin
                void'(q.pop_front());
                rcnt = (rcnt + 1) % D;
            end
            if (pa) begin
                q.push_back(d);
                wcnt = (wcnt + 1) % D;
            end
            if (p && full_m && !po) m_ovf = 1;
            if (po && empty_m && !p) m_udf = 1;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (st() !== 13'b000_0101_00_00_00) begin
            fails++;
            $display("FAIL reset_state: got %b expected %b", st(), 13'b000_0101_00_00_00);
        end
        checks++;
        if ({b3.count, b3.empty, b3.full} !== 5'b000_1_0) begin
            fails++;
            $display("FAIL reset_state_d3: got %b expected %b", {b3.count, b3.empty, b3.full}, 5'b00010);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_seq(input string name, input logic [10:0] s [$]);
        foreach (s[i]) begin
            cycle(s[i][10], s[i][9], s[i][8], s[i][7:0]);
            checks++;
            if (obs_wr !== exp_wr) begin
                fails++;
                $display("FAIL %s_wr[%0d]: got %b expected %b", name, i, obs_wr, exp_wr);
            end
            if (exp_pop) begin
                checks++;
                if (obs_dout !== exp_dout) begin
                    fails++;
                    $display("FAIL %s_dout[%0d]: got %h expected %h", name, i, obs_dout, exp_dout);
                end
            end
            checks++;
            if (st() !== mst()) begin
                fails++;
                $display("FAIL %s_state[%0d]: got %b expected %b", name, i, st(), mst());
            end
        end
    endtask

    task automatic test_fill();
        test_seq("fill", '{11'h411, 11'h422, 11'h433, 11'h444});
        checks++;
        if ({b.full, b.wadr} !== 3'b1_00) begin
            fails++;
            $display("FAIL fill_wrap: got %b expected %b", {b.full, b.wadr}, 3'b100);
        end
    endtask

    task automatic test_overflow();
        test_seq("ovf", '{11'h455, 11'h200, 11'h200, 11'h200, 11'h200});
        checks++;
        if ({b.ovf, b.empty} !== 2'b11) begin
            fails++;
            $display("FAIL ovf_sticky: got %b expected %b", {b.ovf, b.empty}, 2'b11);
        end
    endtask

    task automatic test_back_to_back();
        test_seq("b2b", '{11'h100, 11'h411, 11'h422, 11'h433, 11'h444,
                          11'h6AA, 11'h200, 11'h200, 11'h200, 11'h200});
    endtask

    task automatic test_underflow();
        test_seq("udf", '{11'h200, 11'h677, 11'h200});
        checks++;
        if ({b.udf, b.empty} !== 2'b11) begin
            fails++;
            $display("FAIL udf_sticky: got %b expected %b", {b.udf, b.empty}, 2'b11);
        end
    endtask

    task automatic test_clear();
        test_seq("clr", '{11'h100, 11'h401, 11'h402, 11'h403, 11'h404, 11'h405,
                          11'h200, 11'h200, 11'h5EE, 11'h000});
        checks++;
        if ({b.count, b.ovf, b.udf, b.wadr, b.radr} !== 9'd0) begin
            fails++;
            $display("FAIL clr_result: got %b expected %b",
                     {b.count, b.ovf, b.udf, b.wadr, b.radr}, 9'd0);
        end
    endtask

    task automatic test_async_reset();
        test_seq("pre_rst", '{11'h4A1, 11'h4A2, 11'h4A3});
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (st() !== mst()) begin
            fails++;
            $display("FAIL async_reset: got %b expected %b", st(), mst());
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_seq("post_rst", '{11'h4B1, 11'h200});
    endtask

    task automatic test_depth3();
        logic [1:0] exp_w [3] = '{2'd1, 2'd2, 2'd0};
        for (int i = 0; i < 3; i++) begin
            b3.push = 1;
            @(posedge clk);
            #1;
            b3.push = 0;
            checks++;
            if (b3.wadr !== exp_w[i]) begin
                fails++;
                $display("FAIL d3_wadr[%0d]: got %0d expected %0d", i, b3.wadr, exp_w[i]);
            end
        end
        checks++;
        if ({b3.full, b3.count} !== 4'b1_011) begin
            fails++;
            $display("FAIL d3_full: got %b expected %b", {b3.full, b3.count}, 4'b1011);
        end
        for (int i = 0; i < 3; i++) begin
            b3.pop = 1;
            @(posedge clk);
            #1;
            b3.pop = 0;
            checks++;
            if (b3.radr !== exp_w[i]) begin
                fails++;
                $display("FAIL d3_radr[%0d]: got %0d expected %0d", i, b3.radr, exp_w[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [10:0] s [$];
        for (int i = 0; i < 300; i++) begin
            s.push_back({1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0), 8'($urandom)});
        end
        test_seq("rand", s);
    endtask

    initial begin
        b.push = 0; b.pop = 0; b.clr = 0;
        b3.push = 0; b3.pop = 0; b3.clr = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_fill();
        test_overflow();
        test_back_to_back();
        test_underflow();
        test_clear();
        test_async_reset();
        test_depth3();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
